pipe_seq_ctrl: RTL and testbench
================================

Name: pipe_seq_ctrl

Overview:
Central pipeline sequencer for the 5-stage MIPS core. Drives the PC control inputs (halt, pc_bj, pc_src_in, nop_lock_id) and the IF/ID and ID/EX flush/freeze controls. Arbitrates between halt, memory-busy freeze, EX-stage branch/jump redirect and load-use stall. Keeps performance counters and a memory-wait watchdog.

Parameters:
CNT_W, 32, width of all performance counters (wrap on overflow)
MEM_TIMEOUT, 16, consecutive mem_busy cycles tolerated before mem_err

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_rs, id_rt  in  5 each  source register numbers of instruction in ID
id_use_rs, id_use_rt  in  1 each  ID instruction actually reads rs / rt
ex_rd  in  5  destination register of instruction in EX
ex_mem_read  in  1  EX instruction is a load
ex_bj  in  1  branch taken or jump resolved in EX
ex_target  in  32  redirect target (word address)
mem_busy  in  1  data memory not ready; whole pipeline must freeze
wb_halt  in  1  syscall-halt retiring in WB (single-cycle pulse)
resume  in  1  restart request while halted
halt  out  1  to PC; high in HALT state
pc_bj  out  1  to PC; redirect this cycle
pc_src  out  32  to PC pc_src_in; equals ex_target when pc_bj=1, else 0
nop_lock_id  out  1  to PC and IF/ID; hold PC and IF/ID
flush_id  out  1  clear IF/ID to NOP
flush_ex  out  1  clear ID/EX to NOP (bubble)
freeze  out  1  all pipeline registers hold
mem_err  out  1  sticky watchdog flag
cycle_cnt, stall_cnt, flush_cnt, memwait_cnt  out  CNT_W each  performance counters

Behaviour:
- States: RUN, FREEZE, HALT. Reset (async, rst_n=0): state RUN, all counters 0, mem_err 0, wait counter 0. Control outputs are combinational from state and inputs; during reset all are 0.
- Load-use hazard lu = ex_mem_read & ex_rd!=0 & ((id_use_rs & ex_rd==id_rs) | (id_use_rt & ex_rd==id_rt)).
- Output priority, evaluated each cycle:
  1. HALT: halt=1; all other controls 0.
  2. mem_busy=1 (RUN or FREEZE): freeze=1, nop_lock_id=1; pc_bj, flush_* 0. A branch in EX is held and taken once mem_busy drops.
  3. ex_bj=1: pc_bj=1, pc_src=ex_target, flush_id=1, flush_ex=1; lu ignored.
  4. lu=1: nop_lock_id=1, flush_ex=1 for one cycle only. Next cycle the load has left EX, so lu clears.
  5. Otherwise all 0.
- Transitions:
  - RUN->FREEZE when mem_busy=1.
  - FREEZE->RUN when mem_busy=0.
  - Any->HALT when wb_halt=1, taking precedence over mem_busy.
  - HALT->RUN when resume=1 and wb_halt=0.
  - resume in RUN or FREEZE is ignored.
- Watchdog: wait counter increments each cycle in FREEZE and clears on leaving FREEZE. When it reaches MEM_TIMEOUT with mem_busy still 1, next state is HALT and mem_err is set. mem_err clears only on reset.
- Counters, all wrapping:
  - cycle_cnt +1 every cycle not in HALT.
  - stall_cnt +1 per cycle with priority-4 active.
  - flush_cnt +1 per cycle with pc_bj=1.
  - memwait_cnt +1 per FREEZE cycle.
- Reset asserted mid-FREEZE or mid-HALT: immediate return to RUN with counters cleared.

Test Plan:
- Reset: rst_n=0 for 3 clk, then 1 -> all outputs 0, state RUN; cycle_cnt=5 after 5 more clk.
- Load-use: ex_mem_read=1, ex_rd=8, id_rs=8, id_use_rs=1 for 1 cycle -> nop_lock_id=1, flush_ex=1 that cycle, stall_cnt=1. Repeat with ex_rd=0 -> no stall.
- Branch vs load-use: ex_bj=1, ex_target=0x40, lu=1 same cycle -> pc_bj=1, pc_src=0x40, flush_id=flush_ex=1, nop_lock_id=0, flush_cnt=1, stall_cnt unchanged.
- Freeze with held branch: mem_busy=1 for 4 cycles with ex_bj=1 -> freeze=1, pc_bj=0 for 4 cycles. Cycle 5: pc_bj=1. memwait_cnt=4, mem_err=0.
- Watchdog: mem_busy held 20 cycles -> after 16 FREEZE cycles, state HALT, halt=1, mem_err=1; mem_err persists after resume.
- Halt/resume: wb_halt pulse -> halt=1, cycle_cnt frozen. resume with wb_halt=1 -> stays HALT. resume alone -> RUN next cycle. rst_n=0 while halted -> RUN, counters 0.

Source files
------------

// File: rtl/pipe_seq_ctrl.sv
// Pipeline sequencer for the 5-stage MIPS core: arbitrates halt, memory freeze,
// EX redirect and load-use stall, and keeps performance counters plus a memory watchdog.
module pipe_seq_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_bj,
  input  logic [31:0]      ex_target,
  input  logic             mem_busy,
  input  logic             wb_halt,
  input  logic             resume,
  output logic             halt,
  output logic             pc_bj,
  output logic [31:0]      pc_src,
  output logic             nop_lock_id,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             freeze,
  output logic             mem_err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] memwait_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FREEZE = 2'd1,
    ST_HALT   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [WAIT_W-1:0] r_wait;
  logic              r_mem_err;
  logic [CNT_W-1:0]  r_cycle;
  logic [CNT_W-1:0]  r_stall;
  logic [CNT_W-1:0]  r_flush;
  logic [CNT_W-1:0]  r_memwait;
  logic              w_lu;
  logic              w_wd_trip;
  logic              w_stall;

  assign w_lu = ex_mem_read && (ex_rd != 5'd0) &&
                ((id_use_rs && (ex_rd == id_rs)) || (id_use_rt && (ex_rd == id_rt)));

  // r_wait holds completed FREEZE cycles, so this fires on the MEM_TIMEOUT-th one
  assign w_wd_trip = (r_state == ST_FREEZE) && mem_busy &&
                     (r_wait >= WAIT_W'(MEM_TIMEOUT - 1));

  // Prioritised control outputs; everything is forced low while reset is held
  always_comb begin
    halt        = 1'b0;
    pc_bj       = 1'b0;
    pc_src      = 32'd0;
    nop_lock_id = 1'b0;
    flush_id    = 1'b0;
    flush_ex    = 1'b0;
    freeze      = 1'b0;
    w_stall     = 1'b0;
    if (!rst_n) begin
      halt = 1'b0;
    end else if (r_state == ST_HALT) begin
      halt = 1'b1;
    end else if (mem_busy) begin
      freeze      = 1'b1;
      nop_lock_id = 1'b1;
    end else if (ex_bj) begin
      pc_bj    = 1'b1;
      pc_src   = ex_target;
      flush_id = 1'b1;
      flush_ex = 1'b1;
    end else if (w_lu) begin
      nop_lock_id = 1'b1;
      flush_ex    = 1'b1;
      w_stall     = 1'b1;
    end else begin
      w_stall = 1'b0;
    end
  end

  // Next-state logic; wb_halt overrides every other request
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_RUN: begin
        if (wb_halt)       w_next = ST_HALT;
        else if (mem_busy) w_next = ST_FREEZE;
        else               w_next = ST_RUN;
      end
      ST_FREEZE: begin
        if (wb_halt || w_wd_trip) w_next = ST_HALT;
        else if (!mem_busy)       w_next = ST_RUN;
        else                      w_next = ST_FREEZE;
      end
      ST_HALT: begin
        if (resume && !wb_halt) w_next = ST_RUN;
        else                    w_next = ST_HALT;
      end
      default: w_next = ST_RUN;
    endcase
  end

  // State register, watchdog wait counter and sticky error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_RUN;
      r_wait    <= '0;
      r_mem_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == ST_FREEZE) && (w_next == ST_FREEZE)) r_wait <= r_wait + WAIT_W'(1);
      else                                                 r_wait <= '0;
      if (w_wd_trip) r_mem_err <= 1'b1;
      else           r_mem_err <= r_mem_err;
    end
  end

  // Wrapping performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle   <= '0;
      r_stall   <= '0;
      r_flush   <= '0;
      r_memwait <= '0;
    end else begin
      if (r_state != ST_HALT)   r_cycle   <= r_cycle + CNT_W'(1);
      else                      r_cycle   <= r_cycle;
      if (w_stall)              r_stall   <= r_stall + CNT_W'(1);
      else                      r_stall   <= r_stall;
      if (pc_bj)                r_flush   <= r_flush + CNT_W'(1);
      else                      r_flush   <= r_flush;
      if (r_state == ST_FREEZE) r_memwait <= r_memwait + CNT_W'(1);
      else                      r_memwait <= r_memwait;
    end
  end

  assign mem_err     = r_mem_err;
  assign cycle_cnt   = r_cycle;
  assign stall_cnt   = r_stall;
  assign flush_cnt   = r_flush;
  assign memwait_cnt = r_memwait;

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Self-checking bench for pipe_seq_ctrl: vector table, directed corner sequences and
// random stimulus compared every cycle against a behavioural model.
module tb_pipe_seq_ctrl;
  localparam int CNT_W = 32;
  localparam int MEM_TIMEOUT = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic id_use_rs, id_use_rt, ex_mem_read, ex_bj, mem_busy, wb_halt, resume;
  logic [31:0] ex_target;
  logic halt, pc_bj, nop_lock_id, flush_id, flush_ex, freeze, mem_err;
  logic [31:0] pc_src;
  logic [CNT_W-1:0] cycle_cnt, stall_cnt, flush_cnt, memwait_cnt;

  pipe_seq_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_bj(ex_bj),
    .ex_target(ex_target), .mem_busy(mem_busy), .wb_halt(wb_halt), .resume(resume),
    .halt(halt), .pc_bj(pc_bj), .pc_src(pc_src), .nop_lock_id(nop_lock_id),
    .flush_id(flush_id), .flush_ex(flush_ex), .freeze(freeze), .mem_err(mem_err),
    .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .memwait_cnt(memwait_cnt)
  );

  int checks = 0;
  int failures = 0;

  // Behavioural model: halted flag plus length of the current mem_busy streak
  bit m_halted, m_err;
  int m_streak;
  logic [CNT_W-1:0] m_cyc, m_stall, m_flush, m_mw;

  typedef struct {
    logic [4:0] rs, rt; logic urs, urt; logic [4:0] rd; logic mr, bj; logic [31:0] tgt; logic mb;
    logic e_bj, e_nop, e_fid, e_fex, e_frz;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0; ex_rd = 5'd0;
    ex_mem_read = 1'b0; ex_bj = 1'b0; ex_target = 32'd0; mem_busy = 1'b0;
    wb_halt = 1'b0; resume = 1'b0;
  endtask

  task automatic model_reset();
    m_halted = 1'b0; m_err = 1'b0; m_streak = 0;
    m_cyc = '0; m_stall = '0; m_flush = '0; m_mw = '0;
  endtask

  // Check one cycle (inputs already applied) against the model, then advance one clock
  task automatic run_cycle();
    logic lu, e_halt, e_bj, e_nop, e_fid, e_fex, e_frz;
    logic [31:0] e_src;
    #1;
    lu = ex_mem_read && (ex_rd != 5'd0) &&
         ((id_use_rs && ex_rd == id_rs) || (id_use_rt && ex_rd == id_rt));
    e_halt = 1'b0; e_bj = 1'b0; e_nop = 1'b0; e_fid = 1'b0; e_fex = 1'b0; e_frz = 1'b0;
    e_src = 32'd0;
    if (m_halted) e_halt = 1'b1;
    else if (mem_busy) begin e_frz = 1'b1; e_nop = 1'b1; end
    else if (ex_bj) begin e_bj = 1'b1; e_src = ex_target; e_fid = 1'b1; e_fex = 1'b1; end
    else if (lu) begin e_nop = 1'b1; e_fex = 1'b1; end
    chk("m_halt", halt, e_halt);
    chk("m_pc_bj", pc_bj, e_bj);
    chk("m_pc_src", pc_src, e_src);
    chk("m_nop_lock_id", nop_lock_id, e_nop);
    chk("m_flush_id", flush_id, e_fid);
    chk("m_flush_ex", flush_ex, e_fex);
    chk("m_freeze", freeze, e_frz);
    chk("m_mem_err", mem_err, m_err);
    chk("m_cycle_cnt", cycle_cnt, m_cyc);
    chk("m_stall_cnt", stall_cnt, m_stall);
    chk("m_flush_cnt", flush_cnt, m_flush);
    chk("m_memwait_cnt", memwait_cnt, m_mw);
    if (!m_halted) m_cyc = m_cyc + 1;
    if (!m_halted && !mem_busy && !ex_bj && lu) m_stall = m_stall + 1;
    if (e_bj) m_flush = m_flush + 1;
    if (!m_halted && m_streak > 0) m_mw = m_mw + 1;
    if (!m_halted && mem_busy && m_streak >= MEM_TIMEOUT) m_err = 1'b1;
    if (wb_halt) begin m_halted = 1'b1; m_streak = 0; end
    else if (m_halted) begin if (resume) m_halted = 1'b0; end
    else if (mem_busy && m_streak >= MEM_TIMEOUT) begin m_halted = 1'b1; m_streak = 0; end
    else if (mem_busy) m_streak++;
    else m_streak = 0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{5'd3, 5'd4, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 32'd0,      1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{5'd1, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 32'd0,      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 32'd0,      1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b0, 1'b0, 32'd0,      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 32'd0,      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{5'd2, 5'd9, 1'b1, 1'b1, 5'd2, 1'b1, 1'b1, 32'h1234,   1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{5'd2, 5'd9, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 32'hBEEF,   1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{5'd6, 5'd9, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 32'd0,      1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    // Reset: outputs held low even with active inputs
    idle();
    rst_n = 1'b0;
    mem_busy = 1'b1; ex_bj = 1'b1; ex_target = 32'h55; ex_mem_read = 1'b1; ex_rd = 5'd3;
    id_rs = 5'd3; id_use_rs = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_freeze", freeze, 1'b0);
    chk("rst_pc_bj", pc_bj, 1'b0);
    chk("rst_pc_src", pc_src, 32'd0);
    chk("rst_nop", nop_lock_id, 1'b0);
    chk("rst_cycle_cnt", cycle_cnt, 32'd0);
    idle();
    rst_n = 1'b1;
    model_reset();
    repeat (5) run_cycle();
    chk("rst_cycle5", cycle_cnt, 32'd5);

    // Vector table
    do_reset();
    for (int i = 0; i < 8; i++) begin
      id_rs = tbl[i].rs; id_rt = tbl[i].rt; id_use_rs = tbl[i].urs; id_use_rt = tbl[i].urt;
      ex_rd = tbl[i].rd; ex_mem_read = tbl[i].mr; ex_bj = tbl[i].bj; ex_target = tbl[i].tgt;
      mem_busy = tbl[i].mb;
      #1;
      chk($sformatf("tbl%0d_pc_bj", i), pc_bj, tbl[i].e_bj);
      chk($sformatf("tbl%0d_nop", i), nop_lock_id, tbl[i].e_nop);
      chk($sformatf("tbl%0d_flush_id", i), flush_id, tbl[i].e_fid);
      chk($sformatf("tbl%0d_flush_ex", i), flush_ex, tbl[i].e_fex);
      chk($sformatf("tbl%0d_freeze", i), freeze, tbl[i].e_frz);
      chk($sformatf("tbl%0d_pc_src", i), pc_src, tbl[i].e_bj ? tbl[i].tgt : 32'd0);
      run_cycle();
    end

    // Load-use stall, then the same pattern on r0
    do_reset();
    ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1;
    #1;
    chk("lu_nop", nop_lock_id, 1'b1);
    chk("lu_flush_ex", flush_ex, 1'b1);
    run_cycle();
    idle();
    #1;
    chk("lu_stall_cnt", stall_cnt, 32'd1);
    chk("lu_cleared", nop_lock_id, 1'b0);
    run_cycle();
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_use_rs = 1'b1;
    #1;
    chk("lu_r0_nop", nop_lock_id, 1'b0);
    run_cycle();
    idle();
    #1;
    chk("lu_r0_stall_cnt", stall_cnt, 32'd1);
    run_cycle();

    // Branch beats load-use
    do_reset();
    ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1;
    ex_bj = 1'b1; ex_target = 32'h40;
    #1;
    chk("bj_pc_bj", pc_bj, 1'b1);
    chk("bj_pc_src", pc_src, 32'h40);
    chk("bj_flush_id", flush_id, 1'b1);
    chk("bj_flush_ex", flush_ex, 1'b1);
    chk("bj_nop", nop_lock_id, 1'b0);
    run_cycle();
    idle();
    #1;
    chk("bj_flush_cnt", flush_cnt, 32'd1);
    chk("bj_stall_cnt", stall_cnt, 32'd0);
    run_cycle();

    // Freeze holds a branch until memory is ready
    do_reset();
    ex_bj = 1'b1; ex_target = 32'h80; mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("frz%0d_freeze", i), freeze, 1'b1);
      chk($sformatf("frz%0d_pc_bj", i), pc_bj, 1'b0);
      run_cycle();
    end
    mem_busy = 1'b0;
    #1;
    chk("frz_release_pc_bj", pc_bj, 1'b1);
    chk("frz_release_freeze", freeze, 1'b0);
    run_cycle();
    idle();
    #1;
    chk("frz_memwait_cnt", memwait_cnt, 32'd4);
    chk("frz_mem_err", mem_err, 1'b0);
    chk("frz_flush_cnt", flush_cnt, 32'd1);
    run_cycle();

    // Watchdog: 1 RUN cycle, 16 FREEZE cycles, then HALT
    do_reset();
    mem_busy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk($sformatf("wd%0d_halt", i), halt, (i >= 17) ? 1'b1 : 1'b0);
      run_cycle();
    end
    chk("wd_mem_err", mem_err, 1'b1);
    chk("wd_memwait_cnt", memwait_cnt, 32'd16);
    mem_busy = 1'b0; resume = 1'b1;
    run_cycle();
    resume = 1'b0;
    #1;
    chk("wd_resumed", halt, 1'b0);
    chk("wd_err_sticky", mem_err, 1'b1);
    run_cycle();

    // Halt / resume / reset while halted
    do_reset();
    run_cycle();
    run_cycle();
    wb_halt = 1'b1;
    run_cycle();
    wb_halt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hlt_halt", halt, 1'b1);
      chk("hlt_cycle_frozen", cycle_cnt, 32'd3);
      run_cycle();
    end
    resume = 1'b1; wb_halt = 1'b1;
    run_cycle();
    wb_halt = 1'b0; resume = 1'b0;
    #1;
    chk("hlt_resume_blocked", halt, 1'b1);
    resume = 1'b1;
    run_cycle();
    resume = 1'b0;
    #1;
    chk("hlt_resumed", halt, 1'b0);
    chk("hlt_cycle_after", cycle_cnt, 32'd3);
    run_cycle();
    #1;
    chk("hlt_cycle_counting", cycle_cnt, 32'd4);
    wb_halt = 1'b1;
    run_cycle();
    wb_halt = 1'b0;
    #1;
    chk("hlt_again", halt, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("hlt_rst_halt", halt, 1'b0);
    chk("hlt_rst_cycle", cycle_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run_cycle();

    // Reset in the middle of FREEZE
    mem_busy = 1'b1;
    repeat (3) run_cycle();
    rst_n = 1'b0;
    #1;
    chk("frzrst_freeze", freeze, 1'b0);
    chk("frzrst_memwait", memwait_cnt, 32'd0);
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    model_reset();
    run_cycle();

    // Random stimulus against the model
    begin
      int busy_left;
      busy_left = 0;
      for (int n = 0; n < 4000; n++) begin
        id_rs = 5'($urandom_range(0, 3));
        id_rt = 5'($urandom_range(0, 3));
        ex_rd = 5'($urandom_range(0, 3));
        id_use_rs = 1'($urandom_range(0, 1));
        id_use_rt = 1'($urandom_range(0, 1));
        ex_mem_read = ($urandom_range(0, 2) == 0);
        ex_bj = ($urandom_range(0, 4) == 0);
        ex_target = $urandom;
        if (busy_left == 0 && $urandom_range(0, 11) == 0) busy_left = $urandom_range(1, 20);
        mem_busy = (busy_left > 0);
        if (busy_left > 0) busy_left--;
        wb_halt = ($urandom_range(0, 59) == 0);
        resume = ($urandom_range(0, 5) == 0);
        run_cycle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
